// File: rtl/bambu_ext_mem_responder.sv
// Byte-addressed little-endian memory responder for the accelerator master port.
// One IDLE/WAIT/RESP FSM per channel, fixed read and write latencies, sticky error flags.
module bambu_ext_mem_responder #(
  parameter int CHANNELS    = 2,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 32,
  parameter int SIZE_W      = 6,
  parameter int DEPTH_BYTES = 1024,
  parameter int RD_DELAY    = 2,
  parameter int WR_DELAY    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [CHANNELS-1:0]          Mout_oe_ram,
  input  logic [CHANNELS-1:0]          Mout_we_ram,
  input  logic [CHANNELS*ADDR_W-1:0]   Mout_addr_ram,
  input  logic [CHANNELS*DATA_W-1:0]   Mout_Wdata_ram,
  input  logic [CHANNELS*SIZE_W-1:0]   Mout_data_ram_size,
  output logic [CHANNELS*DATA_W-1:0]   M_Rdata_ram,
  output logic [CHANNELS-1:0]          M_DataRdy,
  output logic [CHANNELS-1:0]          err,
  output logic [31:0]                  rd_count,
  output logic [31:0]                  wr_count
);

  localparam int NBYTES_MAX = DATA_W / 8;
  localparam int MEM_AW     = (DEPTH_BYTES > 1) ? $clog2(DEPTH_BYTES) : 1;
  localparam int MAX_DELAY  = (RD_DELAY > WR_DELAY) ? RD_DELAY : WR_DELAY;
  localparam int CNT_W      = (MAX_DELAY > 1) ? $clog2(MAX_DELAY + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  logic [7:0]                 r_mem [DEPTH_BYTES];
  logic [CHANNELS-1:0]        w_wr_en;
  logic [CHANNELS-1:0]        w_rd_done;
  logic [CHANNELS-1:0]        w_wr_done;
  logic [CHANNELS*ADDR_W-1:0] w_wr_addr;
  logic [CHANNELS*DATA_W-1:0] w_wr_data;
  logic [CHANNELS*SIZE_W-1:0] w_wr_nbytes;
  logic [31:0]                r_rd_count;
  logic [31:0]                r_wr_count;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_ch
    state_t              r_state;
    state_t              w_state_nxt;
    logic                r_op_wr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [SIZE_W-1:0]   r_size;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_rdy;
    logic                r_err;
    logic [DATA_W-1:0]   r_rdata;
    logic                w_req;
    logic                w_fire;
    logic                w_valid;
    logic [SIZE_W-1:0]   w_nbytes;
    logic [31:0]         w_end;
    logic [DATA_W-1:0]   w_rdata;

    assign w_req    = Mout_oe_ram[g] | Mout_we_ram[g];
    assign w_nbytes = r_size >> 3'd3;
    assign w_end    = 32'(r_addr) + 32'(w_nbytes);
    assign w_valid  = (r_size != '0) && (r_size[2:0] == 3'b000) &&
                      (32'(r_size) <= 32'(DATA_W)) && (w_end <= 32'(DEPTH_BYTES));
    assign w_fire   = (r_state == S_WAIT) && (r_cnt == '0);

    // Next-state logic; request lines only matter in IDLE.
    always_comb begin
      w_state_nxt = r_state;
      case (r_state)
        S_IDLE: begin
          if (w_req) w_state_nxt = S_WAIT;
          else       w_state_nxt = S_IDLE;
        end
        S_WAIT: begin
          if (r_cnt == '0) w_state_nxt = S_RESP;
          else             w_state_nxt = S_WAIT;
        end
        S_RESP:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
    end

    // Little-endian gather of the latched access; zero for invalid accesses.
    always_comb begin
      w_rdata = '0;
      if (w_valid) begin
        for (int b = 0; b < NBYTES_MAX; b++) begin
          if (32'(b) < 32'(w_nbytes)) w_rdata[b*8 +: 8] = r_mem[MEM_AW'(32'(r_addr) + 32'(b))];
          else                        w_rdata[b*8 +: 8] = 8'h00;
        end
      end else begin
        w_rdata = '0;
      end
    end

    // Request latch, latency counter, response and sticky error.
    always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
        r_op_wr <= 1'b0;
        r_addr  <= '0;
        r_wdata <= '0;
        r_size  <= '0;
        r_cnt   <= '0;
        r_rdy   <= 1'b0;
        r_err   <= 1'b0;
        r_rdata <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_rdy <= 1'b0;
            if (w_req) begin
              r_op_wr <= Mout_we_ram[g];
              r_addr  <= Mout_addr_ram[g*ADDR_W +: ADDR_W];
              r_wdata <= Mout_Wdata_ram[g*DATA_W +: DATA_W];
              r_size  <= Mout_data_ram_size[g*SIZE_W +: SIZE_W];
              r_cnt   <= Mout_we_ram[g] ? CNT_W'(WR_DELAY - 1) : CNT_W'(RD_DELAY - 1);
              if (Mout_oe_ram[g] && Mout_we_ram[g]) r_err <= 1'b1;
            end
          end
          S_WAIT: begin
            if (r_cnt != '0) begin
              r_cnt <= r_cnt - CNT_W'(1);
            end else begin
              r_rdy <= 1'b1;
              if (!r_op_wr) r_rdata <= w_rdata;
              if (!w_valid) r_err <= 1'b1;
            end
          end
          S_RESP:  r_rdy <= 1'b0;
          default: r_rdy <= 1'b0;
        endcase
      end
    end

    assign w_wr_en[g]                        = w_fire & r_op_wr & w_valid;
    assign w_rd_done[g]                      = w_fire & ~r_op_wr;
    assign w_wr_done[g]                      = w_fire & r_op_wr;
    assign w_wr_addr[g*ADDR_W +: ADDR_W]     = r_addr;
    assign w_wr_data[g*DATA_W +: DATA_W]     = r_wdata;
    assign w_wr_nbytes[g*SIZE_W +: SIZE_W]   = w_nbytes;
    assign M_Rdata_ram[g*DATA_W +: DATA_W]   = r_rdata;
    assign M_DataRdy[g]                      = r_rdy;
    assign err[g]                            = r_err;
  end

  // Storage is never reset; later channels are applied last so the highest channel wins.
  always_ff @(posedge clock) begin
    for (int c = 0; c < CHANNELS; c++) begin
      if (w_wr_en[c]) begin
        for (int b = 0; b < NBYTES_MAX; b++) begin
          if (32'(b) < 32'(w_wr_nbytes[c*SIZE_W +: SIZE_W]))
            r_mem[MEM_AW'(32'(w_wr_addr[c*ADDR_W +: ADDR_W]) + 32'(b))] <= w_wr_data[c*DATA_W + b*8 +: 8];
        end
      end
    end
  end

  // Completion counters, including invalid accesses.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_rd_count <= 32'd0;
      r_wr_count <= 32'd0;
    end else begin
      r_rd_count <= r_rd_count + 32'($countones(w_rd_done));
      r_wr_count <= r_wr_count + 32'($countones(w_wr_done));
    end
  end

  assign rd_count = r_rd_count;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_bambu_ext_mem_responder.sv
// Directed bench for bambu_ext_mem_responder with a per-channel response scoreboard.
module tb_bambu_ext_mem_responder;

  localparam int RD_D = 2;
  localparam int WR_D = 1;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        err;
  } entry_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  oe = 2'b00;
  logic [1:0]  we = 2'b00;
  logic [31:0] addr = 32'd0;
  logic [63:0] wdata = 64'd0;
  logic [11:0] size = 12'd0;
  logic [63:0] rdata;
  logic [1:0]  rdy;
  logic [1:0]  err;
  logic [31:0] rd_count;
  logic [31:0] wr_count;

  int     errors = 0;
  int     checks = 0;
  int     cyc = 0;
  entry_t q0[$];
  entry_t q1[$];

  bambu_ext_mem_responder #(
    .CHANNELS(2), .ADDR_W(16), .DATA_W(32), .SIZE_W(6),
    .DEPTH_BYTES(1024), .RD_DELAY(RD_D), .WR_DELAY(WR_D)
  ) dut (
    .clock(clock), .reset(reset),
    .Mout_oe_ram(oe), .Mout_we_ram(we), .Mout_addr_ram(addr),
    .Mout_Wdata_ram(wdata), .Mout_data_ram_size(size),
    .M_Rdata_ram(rdata), .M_DataRdy(rdy), .err(err),
    .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic mon_ch(input int ch);
    entry_t e;
    int     n;
    n = (ch == 0) ? q0.size() : q1.size();
    if (rdy[ch]) begin
      if (n == 0) begin
        check($sformatf("ch%0d_unexpected_rdy", ch), 64'(rdy[ch]), 64'd0);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        check($sformatf("ch%0d_latency", ch), 64'(cyc), 64'(e.due));
        check($sformatf("ch%0d_rdata", ch), 64'(rdata[ch*32 +: 32]), 64'(e.rdata));
        check($sformatf("ch%0d_err", ch), 64'(err[ch]), 64'(e.err));
      end
    end else if (n > 0) begin
      e = (ch == 0) ? q0[0] : q1[0];
      if (cyc > e.due) begin
        check($sformatf("ch%0d_missing_rdy", ch), 64'(rdy[ch]), 64'd1);
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
      end
    end
  endtask

  always @(negedge clock) begin
    for (int ch = 0; ch < 2; ch++) mon_ch(ch);
  end

  task automatic set_req(input int ch, input logic o, input logic w, input logic [15:0] a,
                         input logic [5:0] s, input logic [31:0] wd,
                         input logic [31:0] er, input logic ee, input bit push);
    entry_t e;
    oe[ch] = o;
    we[ch] = w;
    addr[ch*16 +: 16]  = a;
    size[ch*6 +: 6]    = s;
    wdata[ch*32 +: 32] = wd;
    if (push) begin
      e.due   = cyc + 1 + (w ? WR_D : RD_D);
      e.rdata = er;
      e.err   = ee;
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
  endtask

  task automatic drop_all();
    oe = 2'b00;
    we = 2'b00;
    @(negedge clock);
  endtask

  // Request held through the DataRdy cycle, then dropped, then one idle edge.
  task automatic txn(input int ch, input logic o, input logic w, input logic [15:0] a,
                     input logic [5:0] s, input logic [31:0] wd,
                     input logic [31:0] er, input logic ee);
    set_req(ch, o, w, a, s, wd, er, ee, 1'b1);
    repeat ((w ? WR_D : RD_D) + 1) @(negedge clock);
    drop_all();
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("rst_rdy", 64'(rdy), 64'd0);
    check("rst_rdata", rdata, 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_rd_count", 64'(rd_count), 64'd0);
    check("rst_wr_count", 64'(wr_count), 64'd0);
    reset = 1'b0;
    @(negedge clock);

    txn(0, 1'b0, 1'b1, 16'h0010, 6'd32, 32'hDEADBEEF, 32'h0, 1'b0);
    check("wr_count_1", 64'(wr_count), 64'd1);
    txn(0, 1'b1, 1'b0, 16'h0010, 6'd32, 32'h0, 32'hDEADBEEF, 1'b0);
    check("rd_count_1", 64'(rd_count), 64'd1);
    txn(0, 1'b1, 1'b0, 16'h0011, 6'd16, 32'h0, 32'h0000ADBE, 1'b0);

    set_req(0, 1'b0, 1'b1, 16'h0020, 6'd8, 32'h11, 32'h0000ADBE, 1'b0, 1'b1);
    set_req(1, 1'b0, 1'b1, 16'h0020, 6'd8, 32'h22, 32'h0, 1'b0, 1'b1);
    repeat (WR_D + 1) @(negedge clock);
    drop_all();
    txn(0, 1'b1, 1'b0, 16'h0020, 6'd8, 32'h0, 32'h22, 1'b0);

    set_req(0, 1'b1, 1'b0, 16'h0020, 6'd8, 32'h0, 32'h22, 1'b0, 1'b1);
    @(negedge clock);
    set_req(1, 1'b0, 1'b1, 16'h0020, 6'd8, 32'h33, 32'h0, 1'b0, 1'b1);
    repeat (2) @(negedge clock);
    drop_all();
    txn(0, 1'b1, 1'b0, 16'h0020, 6'd8, 32'h0, 32'h33, 1'b0);

    txn(0, 1'b1, 1'b0, 16'd1022, 6'd32, 32'h0, 32'h0, 1'b1);
    check("err0_sticky", 64'(err), 64'd1);

    txn(1, 1'b1, 1'b1, 16'h0040, 6'd8, 32'h5A, 32'h0, 1'b1);
    txn(1, 1'b1, 1'b0, 16'h0040, 6'd8, 32'h0, 32'h5A, 1'b1);
    txn(0, 1'b0, 1'b1, 16'h0030, 6'd8, 32'h77, 32'h0, 1'b1);
    check("rd_count_7", 64'(rd_count), 64'd7);
    check("wr_count_6", 64'(wr_count), 64'd6);

    set_req(0, 1'b0, 1'b1, 16'h0030, 6'd8, 32'h99, 32'h0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("abort_rdy", 64'(rdy), 64'd0);
    @(negedge clock);
    oe = 2'b00;
    we = 2'b00;
    check("abort_rdy_late", 64'(rdy), 64'd0);
    reset = 1'b0;
    check("rst2_err", 64'(err), 64'd0);
    check("rst2_wr_count", 64'(wr_count), 64'd0);
    check("rst2_rdata", rdata, 64'd0);
    @(negedge clock);
    txn(0, 1'b1, 1'b0, 16'h0030, 6'd8, 32'h0, 32'h77, 1'b0);

    repeat (4) @(negedge clock);
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    check("final_rd_count", 64'(rd_count), 64'd1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bambu_ext_mem_responder.md
Name: bambu_ext_mem_responder

Overview:
- Synthesizable external-memory responder for the accelerator's master memory port (Mout_oe_ram / Mout_we_ram / Mout_addr_ram / Mout_Wdata_ram / Mout_data_ram_size in, M_Rdata_ram / M_DataRdy out).
- Byte-addressed, little-endian storage with a fixed read latency and a fixed write latency. There is one independent FSM per channel.
- Used in co-simulation benches and on FPGA prototypes instead of a behavioural memory model.

Parameters:
- CHANNELS, 2, number of independent request channels (ports are concatenated, channel 0 in LSBs).
- ADDR_W, 16, per-channel byte address width.
- DATA_W, 32, per-channel data width in bits (multiple of 8).
- SIZE_W, 6, per-channel access-size field width (size expressed in bits).
- DEPTH_BYTES, 1024, storage size in bytes.
- RD_DELAY, 2, edges from request acceptance to read DataRdy (>=1).
- WR_DELAY, 1, edges from request acceptance to write DataRdy (>=1).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- Mout_oe_ram  in  CHANNELS  read request per channel.
- Mout_we_ram  in  CHANNELS  write request per channel.
- Mout_addr_ram  in  CHANNELS*ADDR_W  byte address.
- Mout_Wdata_ram  in  CHANNELS*DATA_W  write data, LSB-aligned.
- Mout_data_ram_size  in  CHANNELS*SIZE_W  access size in bits: 8, 16, 24 … DATA_W.
- M_Rdata_ram  out  CHANNELS*DATA_W  read data, LSB-aligned, zero-extended.
- M_DataRdy  out  CHANNELS  one-cycle completion pulse per channel.
- err  out  CHANNELS  sticky per-channel protocol/range error.
- rd_count  out  32  total completed reads, all channels.
- wr_count  out  32  total completed writes, all channels.

Behaviour:
- Reset (async, asserted):
  - M_DataRdy=0, M_Rdata_ram=0, err=0, rd_count=0, wr_count=0.
  - All FSMs go to IDLE.
  - Storage contents are not cleared.
  - Reset mid-transaction abandons the transaction: no DataRdy and no write commit.
- Per-channel FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On an edge with oe|we=1, latch op, addr, wdata and size.
  - Load cnt = delay-1, where delay = RD_DELAY for reads and WR_DELAY for writes.
  - Go to WAIT.
- Both oe and we high on one edge: treated as a write, and err[ch] is set.
- WAIT:
  - If cnt>0, decrement cnt.
  - If cnt==0, perform the access, DataRdy<=1, go to RESP.
  - For a read, M_Rdata_ram<=read data.
- RESP:
  - DataRdy<=0 and go to IDLE.
  - Request lines are ignored in this state, because the initiator holds its request through the DataRdy cycle.
- Timing:
  - Request accepted at edge t → DataRdy high between edges t+delay and t+delay+1.
  - Earliest next acceptance on the same channel is edge t+delay+2.
  - Request lines are ignored in WAIT; the latched values are used.
- Access rules:
  - nbytes = size/8.
  - A read returns bytes addr..addr+nbytes-1, little-endian, with upper bits zero.
  - A write updates only nbytes bytes.
  - M_Rdata_ram holds its last value until the next read completes; writes do not change it.
- Invalid access: size==0, size not a multiple of 8, size>DATA_W, or addr+nbytes>DEPTH_BYTES.
  - err[ch] is set.
  - Reads return 0 and writes are dropped.
  - DataRdy is still issued with normal latency; the initiator never hangs.
- err is cleared only by reset.
- Same-edge collisions (accesses are performed at the WAIT→RESP edge):
  - Read and write to the same byte: the read returns the old value.
  - Two writes to the same byte: the higher-numbered channel wins.
- Counters:
  - Increment at the DataRdy-setting edge, including invalid accesses.
  - Add the number of channels completing on that edge.
  - Wrap modulo 2^32.

Test Plan:
- Reset, then ch0 writes we=1, addr=0x10, size=32, wdata=0xDEADBEEF, accepted at edge t → DataRdy[0] high for exactly one cycle after edge t+1; wr_count=1.
- Ch0 reads addr=0x10, size=32, accepted at edge t → DataRdy[0] after edge t+2 with Rdata=0xDEADBEEF.
- Ch0 reads addr=0x11, size=16 → Rdata=0x0000ADBE.
- Request held high through DataRdy then dropped → exactly one transaction per request; rd_count=1.
- Same edge: ch0 writes 0x11 to byte 0x20 and ch1 writes 0x22 to byte 0x20 (size 8); then read 0x20 → 0x22.
- Same edge: ch0 reads 0x20 and ch1 writes 0x33 to 0x20 → ch0 gets 0x22; a subsequent read gets 0x33.
- Read addr=DEPTH_BYTES-2, size=32 → err[0]=1, Rdata=0, DataRdy still pulses.
- oe=we=1 on ch1 → treated as a write, err[1]=1.
- Reset asserted in WAIT of a write to 0x30 → no DataRdy; a later read of 0x30 returns the pre-existing value.
